// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, issues one instruction-memory
// request at a time, applies prioritised redirects and buffers one instruction.
module if_fetch_ctrl #(
    parameter logic [31:0] PC_INITIAL = 32'hbfc00000,
    parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        reset,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ready,
    input  logic        fetch_rvalid,
    input  logic [31:0] fetch_rdata,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    input  logic        if_stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus_4,
    output logic        flush_if
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        WAIT
    } state_t;

    state_t      state, state_next;
    logic [31:0] fetch_pc, fetch_pc_next;
    logic [31:0] req_pc, req_pc_next;
    logic [31:0] inst_next, inst_pc_next;
    logic        inst_valid_next;
    logic        discard, discard_next;
    logic        flush_next;

    logic        handshake;
    logic        redirect;
    logic        consume;
    logic        fill;
    logic [31:0] redirect_target;

    assign fetch_addr     = fetch_pc;
    assign inst_pc_plus_4 = inst_pc + 32'd4;

    always_comb begin
        fetch_req = (state == RUN) && (!inst_valid || !if_stall);
        handshake = fetch_req && fetch_ready;
        consume   = inst_valid && !if_stall;

        // Redirects arriving before the first request are meaningless and ignored.
        redirect = (state != BOOT) && (exc_valid || eret_valid || br_valid);

        if (exc_valid) begin
            redirect_target = EXC_VECTOR;
        end else if (eret_valid) begin
            redirect_target = epc;
        end else begin
            redirect_target = br_target;
        end

        fill = (state == WAIT) && fetch_rvalid && !discard && !redirect;
    end

    always_comb begin
        state_next      = state;
        fetch_pc_next   = fetch_pc;
        req_pc_next     = req_pc;
        inst_next       = inst;
        inst_pc_next    = inst_pc;
        inst_valid_next = inst_valid;
        discard_next    = discard;
        flush_next      = 1'b0;

        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (handshake) begin
                    state_next    = WAIT;
                    req_pc_next   = fetch_pc;
                    fetch_pc_next = fetch_pc + 32'd4;
                end
            end
            WAIT: begin
                if (fetch_rvalid) begin
                    state_next   = RUN;
                    discard_next = 1'b0;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase

        if (fill) begin
            inst_next       = fetch_rdata;
            inst_pc_next    = req_pc;
            inst_valid_next = 1'b1;
        end else if (consume) begin
            inst_valid_next = 1'b0;
        end

        // A return arriving in the redirect cycle is dropped directly, so discard
        // is only armed when the wrong-path response is still to come.
        if (redirect) begin
            fetch_pc_next   = redirect_target;
            inst_valid_next = 1'b0;
            flush_next      = 1'b1;
            if (((state == WAIT) && !fetch_rvalid) || handshake) begin
                discard_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BOOT;
            fetch_pc   <= PC_INITIAL;
            req_pc     <= '0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            discard    <= 1'b0;
            flush_if   <= 1'b0;
        end else begin
            state      <= state_next;
            fetch_pc   <= fetch_pc_next;
            req_pc     <= req_pc_next;
            inst       <= inst_next;
            inst_pc    <= inst_pc_next;
            inst_valid <= inst_valid_next;
            discard    <= discard_next;
            flush_if   <= flush_next;
        end
    end

endmodule
